dsram_responder: RTL and testbench

DSRAM_RESPONDER -- requirements
Module: dsram_responder

---
 rtl/soc_resp_pkg.sv | 45 ++++
 rtl/bram_be_sp.sv | 41 ++++
 rtl/dsram_responder.sv | 130 +++++++++++++
 tb/tb_dsram_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/soc_resp_pkg.sv
// Shared constants and helpers for the data-SRAM responder.
// Holds the CONF region base, the CONF register offsets, the COMPARE reset
// value, the CONF register decoder and the byte-lane merge helper.
package soc_resp_pkg;

  localparam logic [15:0] CONF_BASE   = 16'hBFAF;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF004;
  localparam logic [15:0] OFF_COMPARE = 16'hF008;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    CONF_NONE,
    CONF_TIMER,
    CONF_LED,
    CONF_SWITCH,
    CONF_COMPARE
  } conf_reg_e;

  function automatic conf_reg_e conf_decode(input logic [15:0] offset);
    conf_reg_e sel;
    case (offset)
      OFF_TIMER:   sel = CONF_TIMER;
      OFF_LED:     sel = CONF_LED;
      OFF_SWITCH:  sel = CONF_SWITCH;
      OFF_COMPARE: sel = CONF_COMPARE;
      default:     sel = CONF_NONE;
    endcase
    return sel;
  endfunction

  // Replace only the byte lanes whose write enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = wen[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/bram_be_sp.sv
// Single-port byte-enable block RAM with synchronous read-before-write.
// Ports:
//   i_clk    clock
//   i_en     access enable (read always happens, write per byte lane)
//   i_wen    byte write enables
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data (old word on a write cycle)
// Contents are not reset; the output register holds while i_en is low.
module bram_be_sp #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_wen,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  localparam int DEPTH = 2 ** AW;

  // One byte-wide array per lane so each lane maps onto a plain RAM with
  // its own write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [0:DEPTH-1];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
      if (i_en) begin
        r_rdata <= r_mem[i_addr];
        if (i_wen[gi]) begin
          r_mem[i_addr] <= i_wdata[8*gi +: 8];
        end
      end
    end

    assign o_rdata[8*gi +: 8] = r_rdata;
  end

endmodule

// File: rtl/dsram_responder.sv
// Responder end of the CPU data-SRAM port: one-cycle RAM plus a small CONF
// register block (TIMER, LED, SWITCH, COMPARE) with a sticky timer interrupt.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   data_sram_en      access request this cycle
//   data_sram_wen     byte write enables (0 = read)
//   data_sram_addr    byte address; [31:16]==BFAF selects CONF
//   data_sram_wdata   write data
//   data_sram_rdata   read data, one cycle after the access
//   switch            external switch levels (synchronized internally)
//   led               LED register
//   timer_irq         sticky TIMER==COMPARE interrupt
module dsram_responder
  import soc_resp_pkg::*;
#(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_irq
);

  logic        w_en;
  logic        w_conf;
  logic        w_conf_wr;
  conf_reg_e   w_conf_sel;
  logic [31:0] w_conf_rdata;
  logic [31:0] w_wr_merged;
  logic [31:0] w_ram_rdata;

  logic [31:0] r_timer;
  logic [31:0] r_compare;
  logic [15:0] r_led;
  logic        r_irq;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;
  logic [31:0] r_conf_rdata;
  logic        r_sel_conf;
  logic        r_rdata_zero;

  // Accesses during reset are dropped entirely, including RAM writes.
  assign w_en       = data_sram_en & ~rst;
  assign w_conf     = (data_sram_addr[31:16] == CONF_BASE);
  assign w_conf_wr  = w_en & w_conf & (|data_sram_wen);
  assign w_conf_sel = conf_decode(data_sram_addr[15:0]);

  always_comb begin
    w_conf_rdata = 32'h0;
    case (w_conf_sel)
      CONF_TIMER:   w_conf_rdata = r_timer;
      CONF_LED:     w_conf_rdata = {16'h0, r_led};
      CONF_SWITCH:  w_conf_rdata = {24'h0, r_sw_sync};
      CONF_COMPARE: w_conf_rdata = r_compare;
      default:      w_conf_rdata = 32'h0;
    endcase
  end

  // The pre-write register value merged with the enabled write bytes;
  // unmapped and read-only offsets simply never consume it.
  assign w_wr_merged = merge_bytes(w_conf_rdata, data_sram_wdata, data_sram_wen);

  bram_be_sp #(.AW(RAM_AW)) u_ram (
    .i_clk   (clk),
    .i_en    (w_en & ~w_conf),
    .i_wen   (data_sram_wen),
    .i_addr  (data_sram_addr[RAM_AW+1:2]),
    .i_wdata (data_sram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer      <= TIMER_RST;
      r_compare    <= COMPARE_RST;
      r_led        <= 16'h0;
      r_irq        <= 1'b0;
      r_sw_meta    <= 8'h0;
      r_sw_sync    <= 8'h0;
      r_conf_rdata <= 32'h0;
      r_sel_conf   <= 1'b0;
      r_rdata_zero <= 1'b1;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;

      // Later assignment below lets a CPU write override the increment.
      r_timer <= r_timer + 32'd1;

      if (w_en) begin
        r_sel_conf   <= w_conf;
        r_rdata_zero <= 1'b0;
        if (w_conf) begin
          r_conf_rdata <= w_conf_rdata;
        end
      end

      if (w_conf_wr) begin
        case (w_conf_sel)
          CONF_TIMER:   r_timer   <= w_wr_merged;
          CONF_LED:     r_led     <= w_wr_merged[15:0];
          CONF_COMPARE: r_compare <= w_wr_merged;
          default:      ;
        endcase
      end

      // Clearing by a COMPARE write wins over a same-cycle match.
      if (w_conf_wr && (w_conf_sel == CONF_COMPARE)) begin
        r_irq <= 1'b0;
      end else if (r_timer == r_compare) begin
        r_irq <= 1'b1;
      end
    end
  end

  // RAM and CONF read paths both register once; the registered region flag
  // picks between them, and the zero flag covers the state just after reset.
  assign data_sram_rdata = r_rdata_zero ? 32'h0 :
                           (r_sel_conf ? r_conf_rdata : w_ram_rdata);
  assign led       = r_led;
  assign timer_irq = r_irq;

endmodule

// File: tb/tb_dsram_responder.sv
module tb_dsram_responder;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        irq;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [31:0] A_TIMER   = 32'hBFAF_E000;
  localparam logic [31:0] A_LED     = 32'hBFAF_F000;
  localparam logic [31:0] A_SWITCH  = 32'hBFAF_F004;
  localparam logic [31:0] A_COMPARE = 32'hBFAF_F008;
  localparam logic [31:0] A_UNMAP   = 32'hBFAF_F00C;

  dsram_responder #(.RAM_AW(12), .TIMER_RST(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .timer_irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%08h", name, got);
    end else begin
      $display("FAIL %-14s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  initial begin
    rst = 1'b1;
    sw  = 8'h00;
    drive(1'b0, 4'h0, 32'h0, 32'h0);

    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0,        16'h0};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF, 16'h0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        1'b1, 32'hDEADBEEF, 16'h0};
    vecs[3]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hAAAAAAAA, 1'b1, 32'hDEADBEEF, 16'h0};
    vecs[4]  = '{1'b1, 4'h5, 32'h0000_0010, 32'h11223344, 1'b1, 32'hAAAAAAAA, 16'h0};
    vecs[5]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b1, 32'hAA22AA44, 16'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h0001_4010, 32'h0,        1'b1, 32'hAA22AA44, 16'h0};
    vecs[7]  = '{1'b1, 4'hF, A_LED,         32'h00001234, 1'b1, 32'h0,        16'h1234};
    vecs[8]  = '{1'b1, 4'h0, A_LED,         32'h0,        1'b1, 32'h00001234, 16'h1234};
    vecs[9]  = '{1'b1, 4'h2, A_LED,         32'hFFFF5678, 1'b1, 32'h00001234, 16'h5634};
    vecs[10] = '{1'b1, 4'h0, A_LED,         32'h0,        1'b1, 32'h00005634, 16'h5634};
    vecs[11] = '{1'b1, 4'hF, A_UNMAP,       32'hDEADBEEF, 1'b1, 32'h0,        16'h5634};
    vecs[12] = '{1'b1, 4'h0, A_UNMAP,       32'h0,        1'b1, 32'h0,        16'h5634};
    vecs[13] = '{1'b1, 4'hF, A_SWITCH,      32'hFFFFFFFF, 1'b1, 32'h0,        16'h5634};
    vecs[14] = '{1'b1, 4'h0, A_SWITCH,      32'h0,        1'b1, 32'h0,        16'h5634};
    vecs[15] = '{1'b1, 4'h0, A_COMPARE,     32'h0,        1'b1, 32'hFFFFFFFF, 16'h5634};
    vecs[16] = '{1'b1, 4'hF, 32'h0000_0020, 32'hCAFEF00D, 1'b0, 32'h0,        16'h5634};
    vecs[17] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,        1'b1, 32'hCAFEF00D, 16'h5634};
    vecs[18] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b1, 32'hAA22AA44, 16'h5634};

    // Reset state.
    step(); step();
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);

    // TIMER starts from TIMER_RST and counts every cycle.
    rst = 1'b0;
    drive(1'b1, 4'h0, A_TIMER, 32'h0);
    step();
    check("timer_start", rdata, 32'h0);
    step();
    check("timer_incr", rdata, 32'h1);

    // Table-driven vectors: rdata reflects the access of the same vector.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      step();
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
    end

    // Switch through the synchronizer.
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    sw = 8'h5A;
    step(); step(); step();
    drive(1'b1, 4'h0, A_SWITCH, 32'h0);
    step();
    check("switch_sync", rdata, 32'h0000005A);

    // Timer wrap and interrupt.
    drive(1'b1, 4'hF, A_COMPARE, 32'h1);
    step();
    check("cmp_prewrite", rdata, 32'hFFFFFFFF);
    drive(1'b1, 4'hF, A_TIMER, 32'hFFFFFFFE);
    step();
    check("irq_t0", {31'h0, irq}, 32'h0);
    drive(1'b1, 4'h0, A_TIMER, 32'h0);
    step();
    check("wrap_rd0", rdata, 32'hFFFFFFFE);
    check("irq_t1", {31'h0, irq}, 32'h0);
    step();
    check("wrap_rd1", rdata, 32'hFFFFFFFF);
    check("irq_t2", {31'h0, irq}, 32'h0);
    step();
    check("wrap_rd2", rdata, 32'h0);
    check("irq_t3", {31'h0, irq}, 32'h0);
    step();
    check("wrap_rd3", rdata, 32'h1);
    check("irq_set", {31'h0, irq}, 32'h1);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step(); step();
    check("irq_sticky", {31'h0, irq}, 32'h1);
    check("rdata_hold", rdata, 32'h1);
    drive(1'b1, 4'hF, A_COMPARE, 32'h101);
    step();
    check("irq_clear", {31'h0, irq}, 32'h0);

    // COMPARE write coinciding with a match: clear wins.
    drive(1'b1, 4'hF, A_TIMER, 32'h100);
    step();
    drive(1'b1, 4'h0, A_TIMER, 32'h0);
    step();
    check("timer_wr_prec", rdata, 32'h100);
    drive(1'b1, 4'hF, A_COMPARE, 32'h500);
    step();
    check("cmp_pre_101", rdata, 32'h101);
    check("irq_clr_wins", {31'h0, irq}, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("irq_stays_0", {31'h0, irq}, 32'h0);

    // Reset in the middle of a burst.
    drive(1'b1, 4'hF, 32'h0000_0030, 32'h12345678);
    step();
    rst = 1'b1;
    drive(1'b1, 4'hF, 32'h0000_0010, 32'h0);
    step();
    check("mid_rst_rdata", rdata, 32'h0);
    check("mid_rst_led", {16'h0, led}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    step();
    check("ram_kept_10", rdata, 32'hAA22AA44);
    drive(1'b1, 4'h0, 32'h0000_0030, 32'h0);
    step();
    check("ram_kept_30", rdata, 32'h12345678);
    drive(1'b1, 4'h0, A_COMPARE, 32'h0);
    step();
    check("cmp_after_rst", rdata, 32'hFFFFFFFF);
    drive(1'b1, 4'h0, A_LED, 32'h0);
    step();
    check("led_after_rst", rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
